// File: rtl/spi_xfer_master.sv
// rtl/spi_xfer_master.sv - SPI mode-0 master, 1-16 bit transfers over valid/ready request/response ports
// Optional build macro SPI_MISO_LATE_SAMPLE_EN moves the miso capture to the edge that lowers sck.
module spi_xfer_master #(
  parameter int DIV_W = 8,
  parameter int SS_N  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_data,
  input  logic [3:0]       req_len,
  input  logic [SS_N-1:0]  req_ss,
  input  logic [DIV_W-1:0] req_div,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [15:0]      resp_data,
  output logic             busy,
  output logic             sck,
  output logic [SS_N-1:0]  ss_n,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_RESP
  } state_t;

  localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);

  state_t           state, state_next;
  logic [DIV_W:0]   cnt;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      tx_q;
  logic [15:0]      rx_q;
  logic [3:0]       bit_cnt;
  logic [3:0]       bit_nxt;
  logic             accept;
  logic             h_done;
  logic             last_bit;
  logic             sample;

  assign accept   = req_valid && req_ready;
  assign h_done   = (cnt == {1'b0, div_q});
  assign last_bit = (bit_cnt == 4'd0);
  assign bit_nxt  = bit_cnt - 4'd1;

`ifdef SPI_MISO_LATE_SAMPLE_EN
  assign sample = (state == S_HIGH) && h_done;
`else
  assign sample = (state_next == S_HIGH) && (state != S_HIGH);
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_SETUP;
      S_SETUP: if (h_done) state_next = S_HIGH;
      S_HIGH:  if (h_done) state_next = last_bit ? S_HOLD : S_LOW;
      S_LOW:   if (h_done) state_next = S_HIGH;
      S_HOLD:  if (h_done) state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt    <= '0;
      sck        <= 1'b0;
      ss_n       <= '1;
      mosi       <= 1'b1;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == S_IDLE);
      busy      <= (state_next != S_IDLE);
      // Timed states restart their count on every transition
      if (state_next != state || state == S_IDLE || state == S_RESP)
        cnt <= '0;
      else
        cnt <= cnt + CNT_ONE;

      if (accept) begin
        div_q   <= req_div;
        tx_q    <= req_data;
        bit_cnt <= req_len;
        rx_q    <= '0;
        ss_n    <= ~req_ss;
        mosi    <= req_data[req_len];
        sck     <= 1'b0;
      end

      if (sample)
        rx_q <= {rx_q[14:0], miso};

      if ((state == S_SETUP || state == S_LOW) && h_done)
        sck <= 1'b1;

      if (state == S_HIGH && h_done) begin
        sck <= 1'b0;
        if (!last_bit) begin
          bit_cnt <= bit_nxt;
          mosi    <= tx_q[bit_nxt];
        end
      end

      if (state == S_HOLD && h_done) begin
        ss_n       <= '1;
        mosi       <= 1'b1;
        resp_valid <= 1'b1;
        resp_data  <= rx_q;
      end

      if (state == S_RESP && resp_ready)
        resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_master.sv
// tb/tb_spi_xfer_master.sv - directed self-checking bench for spi_xfer_master
module tb_spi_xfer_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_len;
  logic [7:0]  req_ss;
  logic [7:0]  req_div;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        busy;
  logic        sck;
  logic [7:0]  ss_n;
  logic        mosi;
  logic        miso;

  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  logic        miso_const = 1'b0;
  logic        slv_miso = 1'b0;
  logic [7:0]  slv_byte = 8'h00;
  int          slv_cnt = 0;

`ifdef SPI_MISO_LATE_SAMPLE_EN
  localparam logic [15:0] EXP_ECHO = 16'h003C;
`else
  localparam logic [15:0] EXP_ECHO = 16'h001E;
`endif

  assign miso = (mode == 0) ? mosi : (mode == 1) ? slv_miso : miso_const;

  always #5 clock = ~clock;

  spi_xfer_master #(.DIV_W(8), .SS_N(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_len(req_len), .req_ss(req_ss), .req_div(req_div),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  // Slave: shifts in one byte, then echoes it MSB-first, miso changing on sck rise
  always @(posedge sck) begin
    if (mode == 1) begin
      if (slv_cnt < 8)
        slv_byte = {slv_byte[6:0], mosi};
      else if (slv_cnt < 16)
        slv_miso = slv_byte[15-slv_cnt];
      slv_cnt++;
    end
  end

  task automatic start_req(input logic [15:0] d, input logic [3:0] l,
                           input logic [7:0] s, input logic [7:0] dv);
    @(negedge clock);
    req_data  = d;
    req_len   = l;
    req_ss    = s;
    req_div   = dv;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_data  = 16'hDEAD;
    req_len   = 4'hF;
    req_ss    = 8'hFF;
    req_div   = 8'hFF;
  endtask

  task automatic run_until_resp(input int limit, output int cyc, output int pulses,
                                output int max_hi, output logic [7:0] ss_and,
                                output logic [7:0] ss_or, output logic mosi_and);
    logic prev;
    int   run;
    cyc = 0; pulses = 0; max_hi = 0; run = 0; prev = 1'b0;
    ss_and = 8'hFF; ss_or = 8'h00; mosi_and = 1'b1;
    while (!resp_valid && cyc < limit) begin
      ss_and   = ss_and & ss_n;
      ss_or    = ss_or | ss_n;
      mosi_and = mosi_and & mosi;
      if (sck && !prev) pulses++;
      run  = sck ? run + 1 : 0;
      if (run > max_hi) max_hi = run;
      prev = sck;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", sck); end
    total++; if (ss_n !== 8'hFF) begin bad++; $display("FAIL reset_ss_n got=%h exp=ff", ss_n); end
    total++; if (mosi !== 1'b1) begin bad++; $display("FAIL reset_mosi got=%b exp=1", mosi); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_data !== 16'h0000) begin bad++; $display("FAIL reset_resp_data got=%h exp=0000", resp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_loopback;
    int cyc, pulses, max_hi;
    logic [7:0] s_and, s_or;
    logic m_and;
    mode = 0;
    start_req(16'h00A5, 4'd7, 8'h01, 8'd0);
    total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL loop_accept got busy=%b ready=%b exp busy=1 ready=0", busy, req_ready); end
    run_until_resp(100, cyc, pulses, max_hi, s_and, s_or, m_and);
    total++; if (cyc !== 17) begin bad++; $display("FAIL loop_latency got=%0d exp=17", cyc); end
    total++; if (pulses !== 8) begin bad++; $display("FAIL loop_pulses got=%0d exp=8", pulses); end
    total++; if (max_hi !== 1) begin bad++; $display("FAIL loop_high_width got=%0d exp=1", max_hi); end
    total++; if (s_and !== 8'hFE || s_or !== 8'hFE) begin bad++; $display("FAIL loop_ss_n got and=%h or=%h exp=fe", s_and, s_or); end
    total++; if (resp_data !== 16'h00A5) begin bad++; $display("FAIL loop_data got=%h exp=00a5", resp_data); end
    @(negedge clock);
    total++; if (ss_n !== 8'hFF || mosi !== 1'b1 || req_ready !== 1'b1) begin bad++; $display("FAIL loop_idle got ss_n=%h mosi=%b ready=%b exp ff/1/1", ss_n, mosi, req_ready); end
  endtask

  task automatic test_slave_echo;
    int cyc, pulses, max_hi;
    logic [7:0] s_and, s_or;
    logic m_and;
    slv_cnt = 0; slv_miso = 1'b0; slv_byte = 8'h00;
    mode = 1;
    start_req(16'h3C00, 4'd15, 8'h01, 8'd3);
    run_until_resp(400, cyc, pulses, max_hi, s_and, s_or, m_and);
    total++; if (cyc !== 132) begin bad++; $display("FAIL echo_latency got=%0d exp=132", cyc); end
    total++; if (pulses !== 16) begin bad++; $display("FAIL echo_pulses got=%0d exp=16", pulses); end
    total++; if (max_hi !== 4) begin bad++; $display("FAIL echo_high_width got=%0d exp=4", max_hi); end
    total++; if (slv_byte !== 8'h3C) begin bad++; $display("FAIL echo_slave_rx got=%h exp=3c", slv_byte); end
    total++; if (resp_data !== EXP_ECHO) begin bad++; $display("FAIL echo_data got=%h exp=%h", resp_data, EXP_ECHO); end
    @(negedge clock);
    mode = 0;
  endtask

  task automatic test_reset_mid;
    int rises, n, seen;
    logic prev;
    mode = 0;
    start_req(16'hFFFF, 4'd15, 8'h01, 8'd1);
    rises = 0; n = 0; prev = sck;
    while (rises < 5 && n < 200) begin
      @(negedge clock);
      n++;
      if (sck && !prev) rises++;
      prev = sck;
    end
    total++; if (rises !== 5) begin bad++; $display("FAIL midrst_rises got=%0d exp=5", rises); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if (sck !== 1'b0 || ss_n !== 8'hFF || req_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got sck=%b ss_n=%h ready=%b exp 0/ff/1", sck, ss_n, req_ready); end
    total++; if (busy !== 1'b0 || mosi !== 1'b1) begin bad++; $display("FAIL midrst_busy_mosi got busy=%b mosi=%b exp 0/1", busy, mosi); end
    seen = 0;
    repeat (80) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || sck !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    int cyc, pulses, max_hi, errs;
    logic [7:0] s_and, s_or;
    logic m_and;
    mode = 0;
    resp_ready = 1'b0;
    start_req(16'h0081, 4'd7, 8'h02, 8'd0);
    run_until_resp(100, cyc, pulses, max_hi, s_and, s_or, m_and);
    total++; if (cyc !== 17 || resp_data !== 16'h0081) begin bad++; $display("FAIL bp_first got cyc=%0d data=%h exp 17/0081", cyc, resp_data); end
    req_data = 16'h000B; req_len = 4'd3; req_ss = 8'h04; req_div = 8'd1;
    req_valid = 1'b1;
    errs = 0;
    repeat (10) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== 16'h0081 || req_ready !== 1'b0 || busy !== 1'b1) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", errs); end
    resp_ready = 1'b1;
    @(negedge clock);
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got valid=%b ready=%b busy=%b exp 0/1/0", resp_valid, req_ready, busy); end
    @(negedge clock);
    req_valid = 1'b0;
    total++; if (busy !== 1'b1 || req_ready !== 1'b0 || ss_n !== 8'hFB) begin bad++; $display("FAIL bp_second_accept got busy=%b ready=%b ss_n=%h exp 1/0/fb", busy, req_ready, ss_n); end
    run_until_resp(100, cyc, pulses, max_hi, s_and, s_or, m_and);
    total++; if (cyc !== 18 || pulses !== 4) begin bad++; $display("FAIL bp_second_timing got cyc=%0d pulses=%0d exp 18/4", cyc, pulses); end
    total++; if (resp_data !== 16'h000B) begin bad++; $display("FAIL bp_second_data got=%h exp=000b", resp_data); end
    @(negedge clock);
  endtask

  task automatic test_no_select;
    int cyc, pulses, max_hi;
    logic [7:0] s_and, s_or;
    logic m_and;
    mode = 2;
    miso_const = 1'b1;
    start_req(16'h0001, 4'd0, 8'h00, 8'd0);
    run_until_resp(50, cyc, pulses, max_hi, s_and, s_or, m_and);
    total++; if (s_and !== 8'hFF) begin bad++; $display("FAIL nosel_ss_n got=%h exp=ff", s_and); end
    total++; if (pulses !== 1 || cyc !== 3) begin bad++; $display("FAIL nosel_timing got pulses=%0d cyc=%0d exp 1/3", pulses, cyc); end
    total++; if (m_and !== 1'b1) begin bad++; $display("FAIL nosel_mosi got=%b exp=1", m_and); end
    total++; if (resp_data !== 16'h0001) begin bad++; $display("FAIL nosel_data got=%h exp=0001", resp_data); end
    @(negedge clock);
    mode = 0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_data = 16'h0; req_len = 4'h0; req_ss = 8'h0; req_div = 8'h0;
    test_reset;
    test_loopback;
    test_slave_echo;
    test_reset_mid;
    test_back_to_back;
    test_no_select;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
